// File: rtl/seq_tx_8.sv
// seq_tx_8: parallel-to-serial frame transmitter, MSB first, with optional bit stuffing
module seq_tx_8 #(
  parameter int DATA_W    = 8,
  parameter int STUFF_EN  = 1,
  parameter int STUFF_LEN = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              dout,
  output logic              tx_active,
  output logic              stuff_bit,
  output logic              done
);
  localparam int CW   = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int RMAX = DATA_W > STUFF_LEN ? DATA_W : STUFF_LEN;
  localparam int RW   = $clog2(RMAX + 1);
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    STUFF = 4'b0100,
    DONE  = 4'b1000
  } state_t;
  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_dec;
  logic [RW-1:0]     run, run_n;
  logic              last, last_n, nb, stuff_due;
  logic              dout_n, tx_n, stuff_n, done_n;
  assign ready     = state == IDLE;
  assign cnt_dec   = cnt - 1'b1;
  assign nb        = sh[cnt_dec];
  assign stuff_due = (STUFF_EN != 0) && (run == RW'(STUFF_LEN));
  // cnt indexes the data bit currently on dout; outputs are registered one cycle ahead
  always_comb begin
    state_n = IDLE;
    sh_n    = sh;
    cnt_n   = cnt;
    run_n   = run;
    last_n  = last;
    dout_n  = 1'b1;
    tx_n    = 1'b0;
    stuff_n = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_n = SHIFT;
        sh_n    = data_in;
        cnt_n   = CW'(DATA_W - 1);
        run_n   = RW'(1);
        last_n  = data_in[DATA_W-1];
        dout_n  = data_in[DATA_W-1];
        tx_n    = 1'b1;
      end
      SHIFT, STUFF: if (state == SHIFT && stuff_due) begin
        state_n = STUFF;
        dout_n  = ~last;
        tx_n    = 1'b1;
        stuff_n = 1'b1;
        run_n   = RW'(1);
        last_n  = ~last;
      end else if (cnt == '0) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        state_n = SHIFT;
        cnt_n   = cnt_dec;
        dout_n  = nb;
        tx_n    = 1'b1;
        run_n   = nb == last ? run + 1'b1 : RW'(1);
        last_n  = nb;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      run       <= '0;
      last      <= 1'b0;
      dout      <= 1'b1;
      tx_active <= 1'b0;
      stuff_bit <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      cnt       <= cnt_n;
      run       <= run_n;
      last      <= last_n;
      dout      <= dout_n;
      tx_active <= tx_n;
      stuff_bit <= stuff_n;
      done      <= done_n;
    end
endmodule

// File: tb/tb_seq_tx_8.sv
// tb_seq_tx_8: directed table-driven bench for seq_tx_8 (stuffing on and off)
module tb_seq_tx_8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic load1 = 1'b0, load0 = 1'b0;
  logic [7:0] d1 = '0, d0 = '0;
  logic ready1, dout1, tx1, sb1, done1;
  logic ready0, dout0, tx0, sb0, done0;
  bit sel = 1'b0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  seq_tx_8 dut (.clk(clk), .rst_n(rst_n), .load(load1), .data_in(d1), .ready(ready1),
                .dout(dout1), .tx_active(tx1), .stuff_bit(sb1), .done(done1));
  seq_tx_8 #(.STUFF_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .load(load0), .data_in(d0), .ready(ready0),
                .dout(dout0), .tx_active(tx0), .stuff_bit(sb0), .done(done0));
  typedef struct {
    bit         s;
    logic [7:0] d;
    logic [15:0] bits;
    logic [15:0] smask;
    int         len;
  } vec_t;
  vec_t vt[9];
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic start(input bit s, input logic [7:0] d);
    int n = 0;
    sel = s;
    #1;
    while (!(sel ? ready0 : ready1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", sel ? ready0 : ready1, 1);
    if (s) begin load0 = 1'b1; d0 = d; end
    else begin load1 = 1'b1; d1 = d; end
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask
  task automatic expect_frame(input logic [15:0] bits, input logic [15:0] smask, input int len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("bit%0d dout", i), sel ? dout0 : dout1, bits[15-i]);
      check($sformatf("bit%0d stuff", i), sel ? sb0 : sb1, smask[15-i]);
      check($sformatf("bit%0d tx", i), sel ? tx0 : tx1, 1);
      check($sformatf("bit%0d ready", i), sel ? ready0 : ready1, 0);
      @(negedge clk);
    end
    check("done_pulse", sel ? done0 : done1, 1);
    check("done_dout", sel ? dout0 : dout1, 1);
    check("done_tx", sel ? tx0 : tx1, 0);
    check("done_ready", sel ? ready0 : ready1, 0);
    @(negedge clk);
    check("idle_ready", sel ? ready0 : ready1, 1);
    check("idle_done", sel ? done0 : done1, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    vt[0] = '{0, 8'hA5, 16'hA500, 16'h0000, 8};
    vt[1] = '{0, 8'hFF, 16'hFB80, 16'h0400, 9};
    vt[2] = '{0, 8'h1F, 16'h1F00, 16'h0080, 9};
    vt[3] = '{0, 8'h00, 16'h0400, 16'h0400, 9};
    vt[4] = '{0, 8'h3C, 16'h3C00, 16'h0000, 8};
    vt[5] = '{0, 8'h07, 16'h0780, 16'h0400, 9};
    vt[6] = '{0, 8'hFC, 16'hFA00, 16'h0400, 9};
    vt[7] = '{1, 8'h00, 16'h0000, 16'h0000, 8};
    vt[8] = '{1, 8'hFF, 16'hFF00, 16'h0000, 8};
    #12;
    check("rst_ready", ready1, 1);
    check("rst_dout", dout1, 1);
    check("rst_tx", tx1, 0);
    check("rst_stuff", sb1, 0);
    check("rst_done", done1, 0);
    check("rst_ready0", ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vt[i]) begin
      start(vt[i].s, vt[i].d);
      expect_frame(vt[i].bits, vt[i].smask, vt[i].len);
    end
    sel = 1'b0;
    load1 = 1'b1;
    d1 = 8'h3C;
    @(negedge clk);
    d1 = 8'hC3;
    expect_frame(16'h3C00, 16'h0000, 8);
    @(negedge clk);
    load1 = 1'b0;
    expect_frame(16'hC300, 16'h0000, 8);
    start(0, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      check("pre_abort_dout", dout1, i[0] ? 0 : 1);
      @(negedge clk);
    end
    check("bit4_dout", dout1, 0);
    rst_n = 1'b0;
    #1;
    check("abort_dout", dout1, 1);
    check("abort_ready", ready1, 1);
    check("abort_tx", tx1, 0);
    check("abort_stuff", sb1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", done1, 0);
      check("abort_idle_tx", tx1, 0);
    end
    start(0, 8'hA5);
    expect_frame(16'hA500, 16'h0000, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
